acc_tmp_unit: RTL

Operand and result register stage directly upstream of the 4-bit ALU in the 4004 datapath. Holds the accumulator (ACC), temporary register (TMP) and carry flag (CY), presents ACC/TMP to the ALU's A/B inputs, and sequences ALU execution. It captures the ALU result from the shared tri-state data bus and the ALU carry back into ACC/CY. A simple valid/ready command interface from the instruction decoder drives it.

---
 rtl/acc_pkg.sv | 24 ++
 rtl/acc_bus_drv.sv | 12 +
 rtl/acc_tmp_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared constants for the ACC/TMP register stage feeding the 4-bit ALU
package acc_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_WRA = 3'b101;
    localparam logic [2:0] OP_CLC = 3'b110;
    localparam logic [2:0] OP_CMC = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/acc_bus_drv.sv
// rtl/acc_bus_drv.sv - tri-state driver onto the shared data bus
module acc_bus_drv #(
    parameter int WIDTH = acc_pkg::WIDTH_DEFAULT
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    inout  wire  [WIDTH-1:0] io_bus
);

    assign io_bus = i_en ? i_data : {WIDTH{1'bz}};

endmodule

// File: rtl/acc_tmp_unit.sv
// rtl/acc_tmp_unit.sv - ACC/TMP/CY operand stage sequencing the ALU over the shared bus
// Optional zero flag on ACC enabled by defining ACC_ZERO_FLAG_EN.
module acc_tmp_unit #(
    parameter int WIDTH = acc_pkg::WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [2:0]       i_op_code,
    inout  wire  [WIDTH-1:0] io_data_bus,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic             o_alu_operation,
    output logic             o_alu_enable,
    input  logic             i_alu_carry,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_carry,
`ifdef ACC_ZERO_FLAG_EN
    output logic             o_zero,
`endif
    output logic             o_busy
);
    import acc_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_tmp;
    logic             r_cy;
    logic             r_alu_en;
    logic             r_alu_op;
    logic             r_drv_en;
    logic             w_acc_we;
    logic             w_tmp_we;
    logic             w_cy_we;
    logic             w_cy_d;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_we    = 1'b0;
        w_tmp_we    = 1'b0;
        w_cy_we     = 1'b0;
        w_cy_d      = r_cy;
        case (r_state)
            ST_IDLE: begin
                if (i_op_valid) begin
                    case (i_op_code)
                        OP_LDT: w_tmp_we = 1'b1;
                        OP_LDA: w_acc_we = 1'b1;
                        OP_CLC: begin
                            w_cy_we = 1'b1;
                            w_cy_d  = 1'b0;
                        end
                        OP_CMC: begin
                            w_cy_we = 1'b1;
                            w_cy_d  = ~r_cy;
                        end
                        OP_ADD, OP_SUB: w_state_nxt = ST_EXEC;
                        OP_WRA:         w_state_nxt = ST_DRIVE;
                        default: ;
                    endcase
                end
            end
            // ALU result is on the bus now; carry is taken raw, no borrow inversion
            ST_EXEC: begin
                w_acc_we    = 1'b1;
                w_cy_we     = 1'b1;
                w_cy_d      = i_alu_carry;
                w_state_nxt = ST_IDLE;
            end
            ST_DRIVE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus-side enables come straight from flops so the ALU and our driver never overlap or glitch
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_tmp    <= '0;
            r_cy     <= 1'b0;
            r_alu_en <= 1'b0;
            r_alu_op <= ALU_OP_ADD;
            r_drv_en <= 1'b0;
        end else begin
            if (w_acc_we) r_acc <= io_data_bus;
            if (w_tmp_we) r_tmp <= io_data_bus;
            if (w_cy_we)  r_cy  <= w_cy_d;
            r_alu_en <= (w_state_nxt == ST_EXEC);
            r_alu_op <= ((w_state_nxt == ST_EXEC) && (i_op_code == OP_SUB)) ? ALU_OP_SUB : ALU_OP_ADD;
            r_drv_en <= (w_state_nxt == ST_DRIVE);
        end
    end

    acc_bus_drv #(.WIDTH(WIDTH)) u_drv (
        .i_en   (r_drv_en),
        .i_data (r_acc),
        .io_bus (io_data_bus)
    );

`ifdef ACC_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_zero <= 1'b1;
        end else if (w_acc_we) begin
            r_zero <= (io_data_bus == '0);
        end
    end

    assign o_zero = r_zero;
`endif

    assign o_op_ready      = (r_state == ST_IDLE);
    assign o_busy          = ~o_op_ready;
    assign o_alu_a         = r_acc;
    assign o_alu_b         = r_tmp;
    assign o_alu_operation = r_alu_op;
    assign o_alu_enable    = r_alu_en;
    assign o_acc           = r_acc;
    assign o_carry         = r_cy;

endmodule
